mem_line_requester: RTL

//   Initiator side of the 4-word-line main-memory protocol. Accepts one cache-line request at a time
//   (refill read or write-back), drives add/write_data/mem_read/mem_write to main memory, tracks

---
 rtl/mem_line_requester.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_line_requester.sv
// Cache-side initiator for the 4-word-line main-memory protocol: one refill read or write-back at a time.
// Optional MEM_TIMEOUT_EN bounds the wait for mem_ready_to_read and reports an abort via resp_err.
module mem_line_requester #(
    parameter int unsigned ADD_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADD_WIDTH-1:0]      req_addr,
    input  logic [4*DATA_WIDTH-1:0]   req_wdata,
    output logic                      resp_valid,
    output logic [4*DATA_WIDTH-1:0]   resp_rdata,
    output logic                      resp_wr_ack,
    output logic                      resp_err,
    output logic [ADD_WIDTH-1:0]      mem_add,
    output logic [DATA_WIDTH-1:0]     mem_write_data,
    output logic                      mem_read,
    output logic                      mem_write,
    input  logic [4*DATA_WIDTH-1:0]   mem_read_data,
    input  logic                      mem_ready_to_read,
    input  logic                      mem_finished_writing
);

    localparam int unsigned LINE_W = ADD_WIDTH - 2;
    localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_BEAT = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                         state_q, state_d;
    logic [LINE_W-1:0]              line_q, line_d;
    logic [3:0][DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [1:0]                     beat_q, beat_d;
    logic [1:0]                     beat_nxt;
    logic                           req_ready_q, req_ready_d;
    logic                           resp_valid_q, resp_valid_d;
    logic [4*DATA_WIDTH-1:0]        resp_rdata_q, resp_rdata_d;
    logic                           ack_q, ack_d;
    logic                           err_q, err_d;
    logic [ADD_WIDTH-1:0]           mem_add_q, mem_add_d;
    logic [DATA_WIDTH-1:0]          mem_wdata_q, mem_wdata_d;
    logic                           mem_read_q, mem_read_d;
    logic                           mem_write_q, mem_write_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           unused_ok;

    // Word-offset bits of the request address are not used; line accesses always start at word 0
    assign unused_ok = ^{req_addr[1:0], (TIMEOUT == 0)};

    assign beat_nxt = 2'(beat_q + 2'd1);

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        wdata_d      = wdata_q;
        beat_d       = beat_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        ack_d        = ack_q;
        err_d        = err_q;
        mem_add_d    = mem_add_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        cnt_d        = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    line_d    = req_addr[ADD_WIDTH-1:2];
                    wdata_d   = req_wdata;
                    ack_d     = 1'b0;
                    err_d     = 1'b0;
                    mem_add_d = {req_addr[ADD_WIDTH-1:2], 2'b00};
                    if (req_write) begin
                        state_d     = WR_BEAT;
                        beat_d      = 2'd0;
                        mem_write_d = 1'b1;
                        mem_wdata_d = req_wdata[DATA_WIDTH-1:0];
                    end else begin
                        state_d    = RD_WAIT;
                        mem_read_d = 1'b1;
                        cnt_d      = '0;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_ready_to_read) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_read_data;
                end else begin
`ifdef MEM_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                    end else begin
                        cnt_d      = CNT_W'(cnt_q + CNT_W'(1));
                        mem_read_d = 1'b1;
                    end
`else
                    mem_read_d = 1'b1;
`endif
                end
            end
            WR_BEAT: begin
                ack_d = ack_q | mem_finished_writing;
                if (beat_q == 2'd3) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    mem_wdata_d  = '0;
                end else begin
                    beat_d      = beat_nxt;
                    mem_write_d = 1'b1;
                    mem_add_d   = {line_q, beat_nxt};
                    mem_wdata_d = wdata_q[beat_nxt];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            line_q       <= '0;
            wdata_q      <= '0;
            beat_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            mem_add_q    <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            wdata_q      <= wdata_d;
            beat_q       <= beat_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            mem_add_q    <= mem_add_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_wr_ack    = ack_q;
    assign resp_err       = err_q;
    assign mem_add        = mem_add_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;

endmodule
